screens_controller: RTL and testbench

- Downstream consumer of the main game screen. It receives the main-screen RGB stream plus its `life`/`score` outputs, and runs the top-level game-flow state machine: start, arm, play, win, lose.
- It selects which full-screen RGB source drives the VGA output.
- It drives the active-low reset of the main-screen stage, so every new game starts from a clean level.
- It tracks the session best score.

---
 rtl/screens_pkg.sv | 15 +
 rtl/key_edge_detect.sv | 23 ++
 rtl/screens_controller.sv | 119 +++++++++++
 tb/tb_screens_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/screens_pkg.sv
// Shared types and constants for the game-flow screen controller.
package screens_pkg;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_ARM   = 3'd1,
    ST_PLAY  = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } screen_state_t;

  localparam logic [7:0] RGB_BLACK   = 8'h00;
  localparam int         FRAME_CNT_W = 8;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge pulse from a level key input.
module key_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic key_d_q;
  logic key_d_d;

  always_comb begin
    key_d_d = level;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) key_d_q <= 1'b0;
    else       key_d_q <= key_d_d;
  end

  assign rise = level & ~key_d_q;

endmodule

// File: rtl/screens_controller.sv
// Top-level game flow: picks the VGA source, resets the main
// screen between games and keeps the session best score.
module screens_controller
  import screens_pkg::*;
#(
  parameter int         ARM_FRAMES  = 30,
  parameter int         HOLD_FRAMES = 120,
  parameter logic [3:0] WIN_SCORE   = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       key5IsPressed,
  input  logic [3:0] life,
  input  logic [3:0] score,
  input  logic [7:0] RGB_screen_main,
  input  logic [7:0] RGB_screen_start,
  input  logic [7:0] RGB_screen_win,
  input  logic [7:0] RGB_screen_lose,
  output logic [7:0] RGB_out,
  output logic       mainResetN,
  output logic [2:0] screen_state,
  output logic [3:0] best_score
);

  localparam logic [FRAME_CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [FRAME_CNT_W-1:0] ARM_LAST =
    FRAME_CNT_W'(ARM_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] HOLD_MIN =
    FRAME_CNT_W'(HOLD_FRAMES);

  screen_state_t          state_q, state_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]             rgb_q, rgb_d;
  logic                   main_rst_n_q, main_rst_n_d;
  logic [3:0]             best_q, best_d;
  logic                   press;
  logic                   game_over;

  key_edge_detect u_key5 (
    .clk   (clk),
    .reset (reset),
    .level (key5IsPressed),
    .rise  (press)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START: if (press) state_d = ST_ARM;
      ST_ARM: begin
        if (startOfFrame && cnt_q == ARM_LAST)
          state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (startOfFrame) begin
          if (life == 4'd0)            state_d = ST_LOSE;
          else if (score >= WIN_SCORE) state_d = ST_WIN;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (press && cnt_q >= HOLD_MIN)
          state_d = ST_START;
      end
      default: state_d = ST_START;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (startOfFrame && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  // Best score is latched only on the game-ending transition.
  assign game_over = (state_q == ST_PLAY) &&
                     (state_d == ST_WIN || state_d == ST_LOSE);

  always_comb begin
    best_d = best_q;
    if (game_over && score > best_q)
      best_d = score;
  end

  always_comb begin
    main_rst_n_d = (state_q == ST_PLAY);
    case (state_q)
      ST_START:        rgb_d = RGB_screen_start;
      ST_ARM, ST_PLAY: rgb_d = RGB_screen_main;
      ST_WIN:          rgb_d = RGB_screen_win;
      ST_LOSE:         rgb_d = RGB_screen_lose;
      default:         rgb_d = RGB_BLACK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_START;
      cnt_q        <= '0;
      rgb_q        <= RGB_BLACK;
      main_rst_n_q <= 1'b0;
      best_q       <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rgb_q        <= rgb_d;
      main_rst_n_q <= main_rst_n_d;
      best_q       <= best_d;
    end
  end

  assign RGB_out      = rgb_q;
  assign mainResetN   = main_rst_n_q;
  assign screen_state = state_q;
  assign best_score   = best_q;

endmodule

// File: tb/tb_screens_controller.sv
// Randomized scoreboard bench for screens_controller.
module tb_screens_controller;

  localparam int ARM  = 30;
  localparam int HOLD = 120;
  localparam int WINS = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       key5IsPressed = 1'b0;
  logic [3:0] life = 4'd3;
  logic [3:0] score = 4'd0;
  logic [7:0] RGB_screen_main = 8'h00;
  logic [7:0] RGB_screen_start = 8'h00;
  logic [7:0] RGB_screen_win = 8'h00;
  logic [7:0] RGB_screen_lose = 8'h00;
  logic [7:0] RGB_out;
  logic       mainResetN;
  logic [2:0] screen_state;
  logic [3:0] best_score;

  screens_controller dut (
    .clk              (clk),
    .reset            (reset),
    .startOfFrame     (startOfFrame),
    .key5IsPressed    (key5IsPressed),
    .life             (life),
    .score            (score),
    .RGB_screen_main  (RGB_screen_main),
    .RGB_screen_start (RGB_screen_start),
    .RGB_screen_win   (RGB_screen_win),
    .RGB_screen_lose  (RGB_screen_lose),
    .RGB_out          (RGB_out),
    .mainResetN       (mainResetN),
    .screen_state     (screen_state),
    .best_score       (best_score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] rgb;
    logic       mrn;
    logic [3:0] best;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: game phase, frames seen in phase, last key level.
  int m_state = 0;
  int m_frames = 0;
  bit m_prev = 0;
  int m_best = 0;

  function automatic void chk(string nm, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               nm, act, expv, $time);
    end
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("screen_state", int'(screen_state), int'(e.st));
      chk("RGB_out", int'(RGB_out), int'(e.rgb));
      chk("mainResetN", int'(mainResetN), int'(e.mrn));
      chk("best_score", int'(best_score), int'(e.best));
    end
  end

  task automatic step(bit key, bit sof, int lf, int sc);
    exp_t e;
    bit   press;
    int   nxt;
    @(negedge clk);
    key5IsPressed    = key;
    startOfFrame     = sof;
    life             = 4'(lf);
    score            = 4'(sc);
    RGB_screen_main  = 8'($urandom);
    RGB_screen_start = 8'($urandom);
    RGB_screen_win   = 8'($urandom);
    RGB_screen_lose  = 8'($urandom);
    press = key && !m_prev;
    case (m_state)
      0:       e.rgb = RGB_screen_start;
      1, 2:    e.rgb = RGB_screen_main;
      3:       e.rgb = RGB_screen_win;
      default: e.rgb = RGB_screen_lose;
    endcase
    e.mrn = (m_state == 2);
    nxt = m_state;
    if (m_state == 0) begin
      if (press) nxt = 1;
    end else if (m_state == 1) begin
      if (sof && m_frames == ARM - 1) nxt = 2;
    end else if (m_state == 2) begin
      if (sof) nxt = (lf == 0) ? 4 : ((sc >= WINS) ? 3 : 2);
    end else begin
      if (press && m_frames >= HOLD) nxt = 0;
    end
    if (m_state == 2 && nxt != 2 && sc > m_best) m_best = sc;
    m_frames = (nxt != m_state) ? 0 : m_frames + int'(sof);
    m_state = nxt;
    m_prev = key;
    e.st = 3'(nxt);
    e.best = 4'(m_best);
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic frames(int n, bit key, int lf, int sc);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) step(key, 0, lf, sc);
      step(key, 1, lf, sc);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_frames = 0;
    m_prev = 0;
    m_best = 0;
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    key5IsPressed = 1'b0;
    startOfFrame = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_state", int'(screen_state), 0);
    chk("rst_rgb", int'(RGB_out), 0);
    chk("rst_mrn", int'(mainResetN), 0);
    chk("rst_best", int'(best_score), 0);
    repeat (n) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic start_game();
    step(1, 0, 3, 0);
    step(0, 0, 3, 0);
    chk("in_arm", int'(screen_state), 1);
    frames(ARM, 0, 3, 1);
    chk("arm_to_play", int'(screen_state), 2);
    chk("mrn_lag", int'(mainResetN), 0);
    step(0, 0, 3, 1);
    chk("mrn_high", int'(mainResetN), 1);
  endtask

  initial begin
    do_reset(3);
    repeat (3) step(0, 0, 3, 0);
    start_game();
    frames(3, 0, 3, 5);
    step(0, 1, 0, 9);
    chk("lose_prio", int'(screen_state), 4);
    chk("best_9", int'(best_score), 9);
    frames(50, 0, 3, 0);
    step(1, 0, 3, 0);
    step(0, 0, 3, 0);
    chk("early_press", int'(screen_state), 4);
    frames(75, 0, 3, 0);
    step(1, 0, 3, 0);
    chk("late_press", int'(screen_state), 0);
    step(0, 0, 3, 0);

    start_game();
    frames(2, 0, 3, 4);
    step(0, 1, 0, 4);
    chk("lose2", int'(screen_state), 4);
    chk("best_keep", int'(best_score), 9);
    frames(130, 1, 3, 0);
    chk("held_key", int'(screen_state), 4);
    step(0, 0, 3, 0);
    step(1, 0, 3, 0);
    chk("exit_lose", int'(screen_state), 0);
    step(0, 0, 3, 0);

    start_game();
    step(0, 1, 2, 9);
    chk("win", int'(screen_state), 3);
    frames(HOLD + 1, 0, 2, 0);
    step(1, 0, 2, 0);
    chk("exit_win", int'(screen_state), 0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 5)),
           int'($urandom_range(0, 15)));
    end

    do_reset(2);
    start_game();
    frames(2, 0, 3, 2);
    reset = 1'b1;
    #1;
    chk("async_state", int'(screen_state), 0);
    chk("async_mrn", int'(mainResetN), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) step(0, 0, 3, 0);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
